test_status_port: RTL

- Synthesizable memory-mapped responder on the data-memory write bus of one `arm` core.
- It is the consuming end of the test-program completion protocol: a test program stores its score to `DONE_ADR` and its progress checkpoints to `CHECK_ADR`.
- The block latches those values, counts cycles, and flags pass/timeout, so the bench and FPGA builds read one sticky status instead of snooping the bus.

---
 rtl/test_status_port_if.sv | 11 +
 rtl/test_status_port.sv | 88 ++++++++
 2 files changed

// File: rtl/test_status_port_if.sv
// Data-memory write bus between one arm core (master) and a memory-mapped responder (slave).
// MemWrite is a single-cycle store strobe sampled on the rising edge; there is no ready, so the slave accepts every store.
interface test_status_port_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output DataAdr, output WriteData, input ReadData);
  modport slave  (input MemWrite, input DataAdr, input WriteData, output ReadData);
endinterface

// File: rtl/test_status_port.sv
// Consuming end of the test-program completion protocol: latches score and checkpoints,
// counts RUN cycles and stores, and reports a sticky PASS/FAIL status.
module test_status_port #(
  parameter logic [31:0] DONE_ADR  = 32'd252,
  parameter logic [31:0] CHECK_ADR = 32'd248,
  parameter logic [31:0] CYC_ADR   = 32'd244,
  parameter logic [31:0] TIMEOUT   = 32'd160
) (
  input  logic                clk,
  input  logic                reset,
  test_status_port_if.slave   bus,
  output logic [31:0]         Score,
  output logic [31:0]         Checkpoint,
  output logic [31:0]         Cycles,
  output logic [15:0]         StoreCnt,
  output logic                Done,
  output logic                Timeout,
  output logic [1:0]          dbgState
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t state;
  state_t stateNext;

  logic doneHit;
  logic checkHit;
  logic lastCycle;

  assign doneHit   = bus.MemWrite && (bus.DataAdr == DONE_ADR);
  assign checkHit  = bus.MemWrite && (bus.DataAdr == CHECK_ADR);
  assign lastCycle = (Cycles == (TIMEOUT - 32'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  // A done store on the timeout edge wins over the timeout.
  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (doneHit) begin
          stateNext = PASS;
        end else if (lastCycle) begin
          stateNext = FAIL;
        end
      end
      PASS:    stateNext = PASS;
      FAIL:    stateNext = FAIL;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Score      <= 32'd0;
      Checkpoint <= 32'd0;
      Cycles     <= 32'd0;
      StoreCnt   <= 16'd0;
    end else if (state == RUN) begin
      Cycles <= Cycles + 32'd1;
      if (bus.MemWrite && (StoreCnt != 16'hFFFF)) begin
        StoreCnt <= StoreCnt + 16'd1;
      end
      if (checkHit) begin
        Checkpoint <= bus.WriteData;
      end
      if (doneHit) begin
        Score <= bus.WriteData;
      end
    end
  end

  assign Done         = (state == PASS);
  assign Timeout      = (state == FAIL);
  assign dbgState     = state;
  assign bus.ReadData = (bus.DataAdr == CYC_ADR) ? Cycles : 32'd0;

endmodule
